// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply (mode=0) or
// restoring compare-subtract divide (mode=1) on a {hi, lo} accumulator.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   trial_s;
  logic [2*XLEN:0] shl_s;

  // Single step of shift-add or restoring divide
  always_comb begin
    sum_s    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    shl_s    = {acc, 1'b0};
    trial_s  = shl_s[2*XLEN:XLEN] - {1'b0, operand};
    acc_next = acc;
    if (mode) begin
      // Top bit of the trial difference is the borrow: set means restore.
      if (!trial_s[XLEN]) begin
        acc_next = {trial_s[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = shl_s[2*XLEN-1:0];
      end
    end else begin
      acc_next = {sum_s, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, counter, sign flags and result register.
// Define MULDIV_FAST_MUL_EN to compute MUL* ops in the start cycle with a multiplier.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]   operand_q, operand_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc_s;
  logic              done_q, done_d, busy_q, busy_d;

  logic              signed_a_s, signed_b_s, neg_a_s, neg_b_s, div_zero_s, div_ovf_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;

  function automatic logic [XLEN-1:0] mul_word(input logic [2*XLEN-1:0] prod,
                                               input logic neg, input logic sel_hi);
    logic [2*XLEN-1:0] p;
    p = neg ? (~prod + 1'b1) : prod;
    if (sel_hi) return p[2*XLEN-1:XLEN];
    else return p[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] div_word(input logic [2*XLEN-1:0] acc,
                                               input logic neg_q, input logic neg_r,
                                               input logic sel_rem);
    logic [XLEN-1:0] q, r;
    q = acc[XLEN-1:0];
    r = acc[2*XLEN-1:XLEN];
    if (sel_rem) return neg_r ? (~r + 1'b1) : r;
    else return neg_q ? (~q + 1'b1) : q;
  endfunction

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc_q),
    .operand  (operand_q),
    .mode     (op_q[2]),
    .acc_next (step_acc_s)
  );

  // Operand sign decode and magnitudes from the request inputs
  always_comb begin
    signed_a_s = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed_b_s = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg_a_s    = signed_a_s & rs1[XLEN-1];
    neg_b_s    = signed_b_s & rs2[XLEN-1];
    mag_a_s    = neg_a_s ? (~rs1 + 1'b1) : rs1;
    mag_b_s    = neg_b_s ? (~rs2 + 1'b1) : rs2;
    div_zero_s = op[2] && (rs2 == {XLEN{1'b0}});
    div_ovf_s  = op[2] && signed_b_s && (rs1 == SMIN) && (rs2 == {XLEN{1'b1}});
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_s;
  assign fast_prod_s = {{XLEN{1'b0}}, mag_a_s} * {{XLEN{1'b0}}, mag_b_s};
`endif

  // Next-state, datapath and result selection
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          neg_a_d   = neg_a_s;
          neg_b_d   = neg_b_s;
          operand_d = mag_b_s;
          acc_d     = {{XLEN{1'b0}}, mag_a_s};
          cnt_d     = CNT_W'(XLEN - 1);
          if (div_zero_s) begin
            result_d = op[1] ? rs1 : {XLEN{1'b1}};
            state_d  = DONE;
          end else if (div_ovf_s) begin
            result_d = op[1] ? {XLEN{1'b0}} : SMIN;
            state_d  = DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op[2]) begin
            result_d = mul_word(fast_prod_s, neg_a_s ^ neg_b_s, op != OP_MUL);
            state_d  = DONE;
`endif
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = step_acc_s;
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIXUP: begin
        if (op_q[2]) begin
          result_d = div_word(acc_q, neg_a_q ^ neg_b_q, neg_a_q, op_q[1]);
        end else begin
          result_d = mul_word(acc_q, neg_a_q ^ neg_b_q, op_q != OP_MUL);
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Redirect abandons the op without touching the visible result.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end else begin
      state_d = state_d;
    end
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      cnt_q     <= {CNT_W{1'b0}};
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      operand_q <= {XLEN{1'b0}};
      acc_q     <= {(2*XLEN){1'b0}};
      result_q  <= {XLEN{1'b0}};
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign stall  = ((state_q == IDLE) & start) | (state_q == CALC) | (state_q == FIXUP);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected results,
// latency/stall checks, early-outs, flush, back-to-back and mid-op reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        stall, busy, done;
  logic [31:0] result;

  int          cyc = 0;
  int          t0_v = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .rs1(rs1_i), .rs2(rs2_i),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    start = 1'b1; op_i = o; rs1_i = a; rs2_i = b;
    t0_v = cyc;
    exp_q.push_back(e);
  endtask

  task automatic run_until_done(input logic hold, output logic got, output int lat,
                                output logic stall_ok, output logic stall_at_done);
    got = 1'b0; lat = 0; stall_ok = 1'b1; stall_at_done = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      #1;
      if (done === 1'b1) begin
        got = 1'b1; lat = cyc - t0_v; stall_at_done = stall;
      end else if (stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_i = 3'd0; rs1_i = 32'd0; rs2_i = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    logic got, sok, sdone; int lat; logic [31:0] e;
    @(negedge clk);
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mul_stall_t0 got=%b exp=1", stall); end
    run_until_done(1'b0, got, lat, sok, sdone);
    total++;
    if (got !== 1'b1) begin
      bad++; $display("FAIL mul_timeout got=no_done exp=done"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++; if (result !== e) begin bad++; $display("FAIL mul_result got=%h exp=%h", result, e); end
      total++; if (lat !== MUL_LAT) begin bad++; $display("FAIL mul_latency got=%0d exp=%0d", lat, MUL_LAT); end
      total++; if (sok !== 1'b1) begin bad++; $display("FAIL mul_stall_hold got=%b exp=1", sok); end
      total++; if (sdone !== 1'b0) begin bad++; $display("FAIL mul_stall_done got=%b exp=0", sdone); end
    end
  endtask

  task automatic test_arith;
    logic [2:0] ops[8]; logic [31:0] as[8], bs[8], es[8];
    logic got, sok, sdone; int lat, el; logic [31:0] e;
    ops[0] = OP_MULHU;  as[0] = 32'hFFFF_FFFF; bs[0] = 32'hFFFF_FFFF; es[0] = 32'hFFFF_FFFE;
    ops[1] = OP_MULH;   as[1] = 32'hFFFF_FFFF; bs[1] = 32'hFFFF_FFFF; es[1] = 32'h0000_0000;
    ops[2] = OP_MULHSU; as[2] = 32'hFFFF_FFFF; bs[2] = 32'd2;        es[2] = 32'hFFFF_FFFF;
    ops[3] = OP_MUL;    as[3] = 32'h1234_5678; bs[3] = 32'd9;        es[3] = 32'hA3D7_0A38;
    ops[4] = OP_DIV;    as[4] = 32'hFFFF_FFF9; bs[4] = 32'd2;        es[4] = 32'hFFFF_FFFD;
    ops[5] = OP_REM;    as[5] = 32'hFFFF_FFF9; bs[5] = 32'd2;        es[5] = 32'hFFFF_FFFF;
    ops[6] = OP_DIVU;   as[6] = 32'd100;       bs[6] = 32'd7;        es[6] = 32'd14;
    ops[7] = OP_REMU;   as[7] = 32'd100;       bs[7] = 32'd7;        es[7] = 32'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(ops[i], as[i], bs[i], es[i]);
      el = ops[i][2] ? 34 : MUL_LAT;
      run_until_done(1'b0, got, lat, sok, sdone);
      total++;
      if (got !== 1'b1) begin
        bad++; $display("FAIL arith%0d_timeout got=no_done exp=done", i); exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        total++; if (result !== e) begin bad++; $display("FAIL arith%0d_result op=%0d got=%h exp=%h", i, ops[i], result, e); end
        total++; if (lat !== el) begin bad++; $display("FAIL arith%0d_latency got=%0d exp=%0d", i, lat, el); end
      end
    end
  endtask

  task automatic test_early_out;
    logic [2:0] ops[5]; logic [31:0] as[5], bs[5], es[5];
    logic got, sok, sdone; int lat; logic [31:0] e;
    ops[0] = OP_DIV;  as[0] = 32'd1234;       bs[0] = 32'd0;        es[0] = 32'hFFFF_FFFF;
    ops[1] = OP_REMU; as[1] = 32'd5;          bs[1] = 32'd0;        es[1] = 32'd5;
    ops[2] = OP_DIV;  as[2] = 32'h8000_0000;  bs[2] = 32'hFFFF_FFFF; es[2] = 32'h8000_0000;
    ops[3] = OP_REM;  as[3] = 32'h8000_0000;  bs[3] = 32'hFFFF_FFFF; es[3] = 32'd0;
    ops[4] = OP_DIVU; as[4] = 32'd7;          bs[4] = 32'd0;        es[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      issue(ops[i], as[i], bs[i], es[i]);
      run_until_done(1'b0, got, lat, sok, sdone);
      total++;
      if (got !== 1'b1) begin
        bad++; $display("FAIL early%0d_timeout got=no_done exp=done", i); exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        total++; if (result !== e) begin bad++; $display("FAIL early%0d_result got=%h exp=%h", i, result, e); end
        total++; if (lat !== 1) begin bad++; $display("FAIL early%0d_latency got=%0d exp=1", i, lat); end
        total++; if (sdone !== 1'b0) begin bad++; $display("FAIL early%0d_stall_done got=%b exp=0", i, sdone); end
      end
    end
  endtask

  task automatic test_flush;
    logic got, sok, sdone; int lat, t0, seen; logic [31:0] e;
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_until_done(1'b0, got, lat, sok, sdone);
    total++;
    if (got !== 1'b1) begin
      bad++; $display("FAIL flush_pre_timeout got=no_done exp=done"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++; if (result !== e) begin bad++; $display("FAIL flush_pre_result got=%h exp=%h", result, e); end
    end
    // DIVU aborted ten cycles in
    @(negedge clk);
    start = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; t0 = cyc;
    for (int k = 0; k < 20 && cyc < t0 + 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    // flush beats start in the same cycle
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op_i = OP_DIVU; rs1_i = 32'd50; rs2_i = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_prio_busy got=%b exp=0", busy); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    total++; if (result !== 32'd14) begin bad++; $display("FAIL flush_result_kept got=%h exp=%h", result, 32'd14); end
  endtask

  task automatic test_back_to_back;
    logic got, sok, sdone; int lat; logic [31:0] e;
    @(negedge clk);
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd333);
    @(negedge clk);
    op_i = OP_REMU; rs1_i = 32'd1000; rs2_i = 32'd3;
    exp_q.push_back(32'd1);
    run_until_done(1'b1, got, lat, sok, sdone);
    total++;
    if (got !== 1'b1) begin
      bad++; $display("FAIL b2b_first_timeout got=no_done exp=done"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++; if (result !== e) begin bad++; $display("FAIL b2b_first_result got=%h exp=%h", result, e); end
      total++; if (lat !== 34) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=34", lat); end
    end
    run_until_done(1'b1, got, lat, sok, sdone);
    start = 1'b0;
    total++;
    if (got !== 1'b1) begin
      bad++; $display("FAIL b2b_second_timeout got=no_done exp=done"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++; if (result !== e) begin bad++; $display("FAIL b2b_second_result got=%h exp=%h", result, e); end
      total++; if (lat !== 69) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=69", lat); end
    end
    @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; op_i = OP_MULHU; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    total++; if (result !== 32'd0) begin bad++; $display("FAIL rstmid_no_write got=%h exp=0", result); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_arith();
    test_early_out();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
